burst_mem_responder: RTL and testbench

BURST_MEM_RESPONDER -- requirements
Module: burst_mem_responder

---
 rtl/burst_mem_responder.sv | 137 +++++++++++++
 tb/tb_burst_mem_responder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_mem_responder.sv
// Line-oriented burst memory responder: accepts a read or write of one 256-bit
// line, waits LATENCY cycles, then moves the line as four 64-bit beats.
module burst_mem_responder #(
  parameter int LATENCY     = 8,
  parameter int DEPTH_LINES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [63:0] mem_wdata,
  output logic        mem_resp,
  output logic [63:0] mem_rdata,
  output logic        busy,
  output logic        err
);

  localparam int         IDX_W    = $clog2(DEPTH_LINES);
  localparam logic [7:0] LAT_LOAD = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_lat, w_lat_nxt;
  logic [1:0]       r_beat, w_beat_nxt;
  logic             r_is_wr, w_is_wr_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic             r_err, w_err_nxt;
  logic             w_req_held;
  logic             w_mem_we;
  logic             w_unused_addr;
  logic [63:0]      r_mem [DEPTH_LINES*4];

  assign w_unused_addr = ^{mem_addr[31:5+IDX_W], mem_addr[4:0]};

  // Control state; storage is kept out of reset so aborted bursts leave prior data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_lat   <= 8'd0;
      r_beat  <= 2'd0;
      r_is_wr <= 1'b0;
      r_idx   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_lat   <= w_lat_nxt;
      r_beat  <= w_beat_nxt;
      r_is_wr <= w_is_wr_nxt;
      r_idx   <= w_idx_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next-state, counters and sticky protocol error.
  always_comb begin
    w_state_nxt = r_state;
    w_lat_nxt   = r_lat;
    w_beat_nxt  = r_beat;
    w_is_wr_nxt = r_is_wr;
    w_idx_nxt   = r_idx;
    w_err_nxt   = r_err;
    w_req_held  = r_is_wr ? mem_write : mem_read;

    case (r_state)
      ST_IDLE: begin
        if (mem_read && mem_write) begin
          w_err_nxt = 1'b1;
        end else if (mem_read || mem_write) begin
          w_is_wr_nxt = mem_write;
          w_idx_nxt   = mem_addr[5 +: IDX_W];
          w_lat_nxt   = LAT_LOAD;
          w_beat_nxt  = 2'd0;
          w_state_nxt = (LAT_LOAD == 8'd0) ? ST_BURST : ST_WAIT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (r_lat <= 8'd1) begin
          w_lat_nxt   = 8'd0;
          w_state_nxt = ST_BURST;
        end else begin
          w_lat_nxt = r_lat - 8'd1;
        end
      end
      ST_BURST: begin
        w_beat_nxt = r_beat + 2'd1;
        if (r_beat == 2'd3) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_BURST;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // A request released before its last beat is flagged; the burst still finishes.
    if (((r_state == ST_WAIT) || ((r_state == ST_BURST) && (r_beat != 2'd3))) && !w_req_held) begin
      w_err_nxt = 1'b1;
    end else begin
      w_err_nxt = w_err_nxt;
    end
  end

  // Beat-wide line storage, indexed by {line, beat}.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[{r_idx, r_beat}] <= mem_wdata;
    end
  end

  // Output decode from registered state.
  always_comb begin
    w_mem_we = (r_state == ST_BURST) && r_is_wr;
    mem_resp = (r_state == ST_BURST);
    busy     = (r_state != ST_IDLE);
    err      = r_err;
    if ((r_state == ST_BURST) && !r_is_wr) begin
      mem_rdata = r_mem[{r_idx, r_beat}];
    end else begin
      mem_rdata = 64'd0;
    end
  end

endmodule

// File: tb/tb_burst_mem_responder.sv
// Bench for burst_mem_responder: two instances (LATENCY 8 and 1) checked
// against a line-level memory model and cycle-offset timing rules.
module tb_burst_mem_responder;

  localparam int LAT0  = 8;
  localparam int LAT1  = 1;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd   [2];
  logic        wr   [2];
  logic [31:0] ad   [2];
  logic [63:0] wd   [2];
  logic        resp [2];
  logic [63:0] rdat [2];
  logic        bsy  [2];
  logic        er   [2];

  always #5 clk = ~clk;

  burst_mem_responder #(.LATENCY(LAT0), .DEPTH_LINES(DEPTH)) dut0 (
    .clk(clk), .rst(rst), .mem_read(rd[0]), .mem_write(wr[0]), .mem_addr(ad[0]),
    .mem_wdata(wd[0]), .mem_resp(resp[0]), .mem_rdata(rdat[0]), .busy(bsy[0]), .err(er[0]));

  burst_mem_responder #(.LATENCY(LAT1), .DEPTH_LINES(DEPTH)) dut1 (
    .clk(clk), .rst(rst), .mem_read(rd[1]), .mem_write(wr[1]), .mem_addr(ad[1]),
    .mem_wdata(wd[1]), .mem_resp(resp[1]), .mem_rdata(rdat[1]), .busy(bsy[1]), .err(er[1]));

  int           n_checks = 0;
  int           n_err    = 0;
  logic [255:0] mdl       [2][DEPTH];
  bit           mdl_valid [2][DEPTH];
  bit           exp_err   [2];

  typedef struct {
    bit           is_wr;
    logic [31:0]  addr;
    logic [255:0] line;
  } vec_t;

  function automatic int lat_of(input int s);
    return (s == 0) ? LAT0 : LAT1;
  endfunction

  function automatic int line_of(input logic [31:0] a);
    return int'((a >> 5) % 32'(DEPTH));
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom();
    return l;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction; cycle 0 is the calling cycle, outputs checked by offset from it.
  task automatic do_txn(input int s, input bit is_wr, input logic [31:0] a,
                        input logic [255:0] wline, input bit hold, input int drop_at,
                        output logic [255:0] got);
    int L;
    int li;
    L   = lat_of(s);
    li  = line_of(a);
    got = '0;
    rd[s] = !is_wr;
    wr[s] = is_wr;
    ad[s] = a;
    chk("accept_busy", 64'(bsy[s]), 64'd0);
    for (int n = 1; n <= L + 4; n++) begin
      bit in_b;
      int k;
      tick();
      in_b = (n >= L) && (n < L + 4);
      k    = n - L;
      if (n == 1) ad[s] = $urandom();
      if (n == drop_at) begin
        rd[s] = 1'b0;
        wr[s] = 1'b0;
      end
      chk("resp", 64'(resp[s]), 64'(in_b));
      chk("busy", 64'(bsy[s]), 64'd1);
      if (in_b) begin
        if (is_wr) begin
          wd[s] = wline[64*k +: 64];
        end else begin
          got[64*k +: 64] = rdat[s];
          if (mdl_valid[s][li]) chk("rdata", rdat[s], mdl[s][li][64*k +: 64]);
        end
      end else begin
        chk("rdata_zero", rdat[s], 64'd0);
      end
      if (n == L + 4 && !hold) begin
        rd[s] = 1'b0;
        wr[s] = 1'b0;
      end
    end
    if (is_wr) begin
      mdl[s][li]       = wline;
      mdl_valid[s][li] = 1'b1;
    end
    if (drop_at > 0 && drop_at <= L + 2) exp_err[s] = 1'b1;
    tick();
    chk("err", 64'(er[s]), 64'(exp_err[s]));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("rst_resp",  64'(resp[s]), 64'd0);
      chk("rst_rdata", rdat[s],       64'd0);
      chk("rst_busy",  64'(bsy[s]),  64'd0);
      chk("rst_err",   64'(er[s]),   64'd0);
      rd[s] = 1'b0;
      wr[s] = 1'b0;
      exp_err[s] = 1'b0;
    end
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    vec_t         tbl [6];
    logic [255:0] got;
    logic [255:0] l_a5;
    logic [255:0] l_cc;
    logic [255:0] l_bb;

    l_a5 = {4{64'hA5A5_A5A5_A5A5_A5A5}};
    l_cc = {4{64'hCCCC_CCCC_CCCC_CCCC}};
    l_bb = {4{64'hBBBB_BBBB_BBBB_BBBB}};
    tbl[0] = '{1'b1, 32'h0000_0100, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}};
    tbl[1] = '{1'b0, 32'h0000_0100, tbl[0].line};
    tbl[2] = '{1'b1, 32'h0000_0000, l_a5};
    tbl[3] = '{1'b0, 32'h0000_0800, l_a5};
    tbl[4] = '{1'b1, 32'h0000_001F, {64'd4, 64'd3, 64'd2, 64'd1}};
    tbl[5] = '{1'b0, 32'hFFFF_F100, tbl[0].line};

    for (int s = 0; s < 2; s++) begin
      rd[s] = 1'b0; wr[s] = 1'b0; ad[s] = 32'd0; wd[s] = 64'd0; exp_err[s] = 1'b0;
      for (int i = 0; i < DEPTH; i++) mdl_valid[s][i] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Table vectors; the first is accepted on the first edge after reset release.
    for (int i = 0; i < 6; i++) begin
      do_txn(0, tbl[i].is_wr, tbl[i].addr, tbl[i].line, 1'b0, 0, got);
      if (!tbl[i].is_wr)
        for (int k = 0; k < 4; k++) chk($sformatf("tbl%0d_beat%0d", i, k), got[64*k +: 64], tbl[i].line[64*k +: 64]);
    end
    do_txn(0, 1'b0, 32'h0000_0000, '0, 1'b0, 0, got);
    chk("alias_low_bits", got[127:64], 64'd2);

    // Back-to-back reads with the request held through DONE.
    do_txn(0, 1'b0, 32'h0000_0100, '0, 1'b1, 0, got);
    do_txn(0, 1'b0, 32'h0000_0100, '0, 1'b0, 0, got);

    // Both requests together: nothing accepted, err sticks until reset.
    rd[0] = 1'b1; wr[0] = 1'b1; ad[0] = 32'h40;
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("both_resp", 64'(resp[0]), 64'd0);
      chk("both_busy", 64'(bsy[0]),  64'd0);
      chk("both_err",  64'(er[0]),   64'd1);
    end
    rd[0] = 1'b0; wr[0] = 1'b0;
    exp_err[0] = 1'b1;
    do_txn(0, 1'b0, 32'h0000_0100, '0, 1'b0, 0, got);
    do_reset();

    // Reset after beat 1 of a write over a pre-filled line.
    do_txn(0, 1'b1, 32'h0000_03C0, l_cc, 1'b0, 0, got);
    rd[0] = 1'b0; wr[0] = 1'b1; ad[0] = 32'h0000_03C0;
    for (int n = 1; n <= LAT0 + 1; n++) begin
      tick();
      if (n >= LAT0) wd[0] = l_bb[63:0];
    end
    tick();
    chk("pre_abort_resp", 64'(resp[0]), 64'd1);
    rst = 1'b1;
    #1;
    chk("abort_resp",  64'(resp[0]), 64'd0);
    chk("abort_rdata", rdat[0],       64'd0);
    chk("abort_busy",  64'(bsy[0]),  64'd0);
    wr[0] = 1'b0;
    do_reset();
    mdl[0][30] = {l_cc[127:0], l_bb[127:0]};
    do_txn(0, 1'b0, 32'h0000_03C0, '0, 1'b0, 0, got);
    chk("abort_b0", got[63:0],    64'hBBBB_BBBB_BBBB_BBBB);
    chk("abort_b1", got[127:64],  64'hBBBB_BBBB_BBBB_BBBB);
    chk("abort_b2", got[191:128], 64'hCCCC_CCCC_CCCC_CCCC);
    chk("abort_b3", got[255:192], 64'hCCCC_CCCC_CCCC_CCCC);

    // LATENCY=1 instance: write, back-to-back reads, then a dropped request.
    do_txn(1, 1'b1, 32'h0000_0040, rand_line(), 1'b0, 0, got);
    do_txn(1, 1'b0, 32'h0000_0040, '0, 1'b1, 0, got);
    do_txn(1, 1'b0, 32'h0000_0040, '0, 1'b0, 0, got);
    do_txn(0, 1'b0, 32'h0000_0100, '0, 1'b0, 2, got);
    do_txn(1, 1'b1, 32'h0000_0060, rand_line(), 1'b0, 2, got);
    do_txn(1, 1'b0, 32'h0000_0060, '0, 1'b0, 0, got);
    do_reset();

    // Randomized traffic against the line model.
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 25; i++) begin
        int          li;
        bit          is_wr;
        bit          hold;
        logic [31:0] a;
        li    = int'($urandom_range(0, 7));
        is_wr = ($urandom_range(0, 1) == 1) || !mdl_valid[s][li];
        hold  = ($urandom_range(0, 3) == 0);
        a     = ($urandom() & ~32'h0000_07E0) | (32'(li) << 5);
        do_txn(s, is_wr, a, rand_line(), hold, 0, got);
        if (!hold) begin
          for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
            chk("gap_busy", 64'(bsy[s]), 64'd0);
            tick();
          end
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
